door_dwell_ctrl: RTL and testbench

//  Elevator door sequencer feeding the dwell-time 7-seg digit stage: drives its pause (door-held

---
 rtl/door_dwell_ctrl_pkg.sv | 20 ++
 rtl/door_dwell_ctrl_if.sv | 28 ++
 rtl/door_dwell_ctrl_tick_gen.sv | 23 ++
 rtl/door_dwell_ctrl.sv | 112 +++++++++++
 tb/tb_door_dwell_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/door_dwell_ctrl_pkg.sv
// Shared door-sequencer types and sizing constants.
package elevator_pkg;

  localparam int DOOR_W = 2;

  typedef enum logic [DOOR_W-1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } door_st_t;

  // Largest of the three phase durations; sizes the shared tick counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/door_dwell_ctrl_if.sv
// Door sequencer signal bundle: car/button inputs and door status outputs.
import elevator_pkg::*;

interface door_dwell_ctrl_if;
  logic     arrive;
  logic     open_btn;
  logic     close_btn;
  logic     obstruct;
  logic     moving;
  logic     pause;
  logic     show;
  logic     door_closed;
  logic     door_done;
  door_st_t state;
  logic     interlock_err;

  // Car controller / buttons side.
  modport master (
    output arrive, open_btn, close_btn, obstruct, moving,
    input  pause, show, door_closed, door_done, state, interlock_err
  );

  // Door sequencer side.
  modport slave (
    input  arrive, open_btn, close_btn, obstruct, moving,
    output pause, show, door_closed, door_done, state, interlock_err
  );
endinterface

// File: rtl/door_dwell_ctrl_tick_gen.sv
// Modulo-DIV prescaler: one-cycle tick while the count sits at DIV-1.
// Tick is decoded from the count register so it is 0 straight out of reset.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Count up, wrap at DIV-1; synchronous clear restarts the period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             cnt <= '0;
    else if (clr || cnt == CW'(DIV - 1)) cnt <= '0;
    else                                 cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CW'(DIV - 1));
endmodule

// File: rtl/door_dwell_ctrl.sv
// Elevator door sequencer: CLOSED->OPENING->OPEN->CLOSING with tick timers,
// reopen on obstruction/open button, and a sticky door/motion interlock flag.
module door_dwell_ctrl
  import elevator_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int SHOW_DIV = 50_000,
  parameter int OPEN_T   = 2,
  parameter int DWELL_T  = 10,
  parameter int CLOSE_T  = 2
) (
  input logic              clk,
  input logic              rst,
  door_dwell_ctrl_if.slave bus
);
  localparam int MAX_T = max3(OPEN_T, DWELL_T, CLOSE_T);
  localparam int TW    = $clog2(MAX_T + 1);

  door_st_t      st, nxt;
  logic [TW-1:0] tcnt;
  logic          tick, show_w;
  logic          last_tick;
  logic          restart, tclr, done_set;
  logic          done_q, ierr_q;
  logic          reopen;

  assign reopen = bus.open_btn | bus.obstruct;

  // Final tick of the current phase (phase length in ticks).
  always_comb begin
    last_tick = 1'b0;
    case (st)
      OPENING: last_tick = tick && (tcnt == TW'(OPEN_T - 1));
      OPEN:    last_tick = tick && (tcnt == TW'(DWELL_T - 1));
      CLOSING: last_tick = tick && (tcnt == TW'(CLOSE_T - 1));
      default: last_tick = 1'b0;
    endcase
  end

  // Next-state: reopen requests win over timer expiry and close_btn.
  always_comb begin
    nxt      = st;
    restart  = 1'b0;
    done_set = 1'b0;
    case (st)
      CLOSED:  if ((bus.arrive | bus.open_btn) & ~bus.moving) nxt = OPENING;
      OPENING: if (last_tick) nxt = OPEN;
      OPEN: begin
        if (reopen)             restart = 1'b1;
        else if (bus.close_btn) nxt = CLOSING;
        else if (last_tick)     nxt = CLOSING;
      end
      CLOSING: begin
        if (reopen) nxt = OPENING;
        else if (last_tick) begin
          nxt      = CLOSED;
          done_set = 1'b1;
        end
      end
      default: nxt = CLOSED;
    endcase
  end

  // Prescaler and tick count restart on every state entry and on a dwell restart.
  assign tclr = (nxt != st) | restart;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tclr),
    .tick (tick)
  );

  tick_gen #(.DIV(SHOW_DIV)) u_show (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .tick (show_w)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= CLOSED;
    else     st <= nxt;
  end

  // Elapsed ticks in the current phase; idle while CLOSED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          tcnt <= '0;
    else if (tclr)                    tcnt <= '0;
    else if (tick && st != CLOSED)    tcnt <= tcnt + 1'b1;
  end

  // door_done registered so it lines up with the first CLOSED cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= done_set;
  end

  // Sticky interlock: motor running while the door is not fully closed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            ierr_q <= 1'b0;
    else if (bus.moving && st != CLOSED) ierr_q <= 1'b1;
  end

  assign bus.state         = st;
  assign bus.pause         = (st == OPEN);
  assign bus.door_closed   = (st == CLOSED);
  assign bus.door_done     = done_q;
  assign bus.show          = show_w;
  assign bus.interlock_err = ierr_q;
endmodule

// File: tb/tb_door_dwell_ctrl.sv
// Directed bench for door_dwell_ctrl with small timer parameters.
module tb_door_dwell_ctrl;
  import elevator_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    string    tag;
    door_st_t st;
    logic     pause;
    logic     closed;
    logic     done;
    logic     ierr;
  } exp_t;

  exp_t sb[$];

  door_dwell_ctrl_if dif();

  door_dwell_ctrl #(
    .TICK_DIV(4), .SHOW_DIV(5), .OPEN_T(2), .DWELL_T(3), .CLOSE_T(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input door_st_t st, input logic done, input logic ierr);
    exp_t e;
    e.tag    = tag;
    e.st     = st;
    e.pause  = (st == OPEN);
    e.closed = (st == CLOSED);
    e.done   = done;
    e.ierr   = ierr;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".state"},  32'(dif.state),       32'(e.st));
    chk({e.tag, ".pause"},  32'(dif.pause),       32'(e.pause));
    chk({e.tag, ".closed"}, 32'(dif.door_closed), 32'(e.closed));
    chk({e.tag, ".done"},   32'(dif.door_done),   32'(e.done));
    chk({e.tag, ".ierr"},   32'(dif.interlock_err), 32'(e.ierr));
  endtask

  // Advance n edges, sampling 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue the expectation, run n edges, then compare.
  task automatic step(input int n, input string tag, input door_st_t st,
                      input logic done, input logic ierr);
    push(tag, st, done, ierr);
    cyc(n);
    pop_check();
  endtask

  initial begin
    dif.arrive = 0; dif.open_btn = 0; dif.close_btn = 0;
    dif.obstruct = 0; dif.moving = 0;

    // Reset state
    #1;
    push("reset", CLOSED, 0, 0);
    pop_check();
    chk("reset.show", 32'(dif.show), 32'd0);
    cyc(2);
    rst = 1'b0;

    // Nominal cycle: arrive at edge 0
    dif.arrive = 1;
    step(1, "nom_e1", OPENING, 0, 0);
    dif.arrive = 0;
    step(7,  "nom_e8",  OPENING, 0, 0);
    step(1,  "nom_e9",  OPEN,    0, 0);
    step(11, "nom_e20", OPEN,    0, 0);
    step(1,  "nom_e21", CLOSING, 0, 0);
    step(7,  "nom_e28", CLOSING, 0, 0);
    step(1,  "nom_e29", CLOSED,  1, 0);
    step(1,  "nom_e30", CLOSED,  0, 0);

    // Obstruct in OPEN restarts dwell
    dif.arrive = 1;
    step(1, "obs_open_entry", OPENING, 0, 0);
    dif.arrive = 0;
    step(8, "obs_open", OPEN, 0, 0);
    cyc(2);
    dif.obstruct = 1;
    step(6, "obs_held", OPEN, 0, 0);
    dif.obstruct = 0;
    step(11, "obs_fall_11", OPEN,    0, 0);
    step(1,  "obs_fall_12", CLOSING, 0, 0);

    // Obstruct in CLOSING reopens with full OPEN_T
    cyc(2);
    dif.obstruct = 1;
    step(1, "reopen_e1", OPENING, 0, 0);
    dif.obstruct = 0;
    step(7, "reopen_e8", OPENING, 0, 0);
    step(1, "reopen_e9", OPEN,    0, 0);

    // open_btn + close_btn: open wins; close_btn alone closes next edge
    dif.open_btn = 1; dif.close_btn = 1;
    step(3, "both_btn", OPEN, 0, 0);
    dif.open_btn = 0;
    step(1, "close_btn", CLOSING, 0, 0);
    dif.close_btn = 0;
    step(7, "close_e7", CLOSING, 0, 0);
    step(1, "close_e8", CLOSED,  1, 0);

    // Requests while moving are ignored in CLOSED
    dif.moving = 1; dif.arrive = 1;
    step(1, "mov_arrive", CLOSED, 0, 0);
    dif.arrive = 0; dif.open_btn = 1;
    step(2, "mov_open", CLOSED, 0, 0);
    dif.open_btn = 0; dif.moving = 0;

    // Moving during OPEN sets sticky interlock
    dif.arrive = 1;
    step(1, "il_entry", OPENING, 0, 0);
    dif.arrive = 0;
    step(8, "il_open", OPEN, 0, 0);
    dif.moving = 1;
    step(1, "il_set", OPEN, 0, 1);
    dif.moving = 0;
    step(3, "il_held", OPEN, 0, 1);

    // Async reset mid-OPEN
    rst = 1'b1;
    #1;
    push("rst_mid", CLOSED, 0, 0);
    pop_check();
    cyc(1);
    rst = 1'b0;

    // show strobes every 5 cycles from reset release
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      chk($sformatf("show_k%0d", k), 32'(dif.show), ((k % 5) == 4) ? 32'd1 : 32'd0);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
